// File: rtl/program_store.sv
// Writable program store for the CPU fetch stage: auto-fills with the NOP opcode
// after reset, accepts a program over a valid/ready load port, serves registered fetches.
module program_store #(
   parameter int                    DATA_WIDTH = 4,
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DEPTH      = 256,
   parameter logic [DATA_WIDTH-1:0] NOP_OPCODE = DATA_WIDTH'(4'b0111)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] addressIn,
   input  logic                  fetchEn,
   output logic [DATA_WIDTH-1:0] dataOut,
   output logic                  dataValid,
   input  logic                  loadStart,
   input  logic                  loadValid,
   input  logic [DATA_WIDTH-1:0] loadData,
   output logic                  loadReady,
   input  logic                  loadEnd,
   output logic [ADDR_WIDTH:0]   loadCount,
   output logic                  busy
);

   localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_LOAD = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  we_s;
   logic [IDX_W-1:0]      waddr_s;
   logic [IDX_W-1:0]      raddr_s;
   logic [DATA_WIDTH-1:0] wdata_s;
   logic                  accept_s;
   logic                  in_range_s;
   logic                  last_s;

   // One pointer serves both the INIT fill and the LOAD write address.
   assign waddr_s    = ptr_q[IDX_W-1:0];
   assign raddr_s    = addressIn[IDX_W-1:0];
   assign in_range_s = ({1'b0, addressIn} < DEPTH_W);
   assign last_s     = (ptr_q == LAST_PTR);
   assign loadReady  = (state_q == ST_LOAD) && !loadStart;
   assign accept_s   = loadValid && loadReady;

   assign dataOut   = data_q;
   assign dataValid = valid_q;
   assign loadCount = count_q;
   assign busy      = (state_q != ST_IDLE);

   // Next-state, write-port and fetch logic.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      data_d  = data_q;
      valid_d = 1'b0;
      we_s    = 1'b0;
      wdata_s = loadData;
      case (state_q)
         ST_INIT: begin
            we_s    = 1'b1;
            wdata_s = NOP_OPCODE;
            if (last_s) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end else begin
               state_d = ST_INIT;
               ptr_d   = ptr_q + ADDR_WIDTH'(1);
            end
         end
         ST_IDLE: begin
            if (fetchEn) begin
               valid_d = 1'b1;
               data_d  = in_range_s ? mem_q[raddr_s] : NOP_OPCODE;
            end else begin
               valid_d = 1'b0;
            end
            if (loadStart) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
               count_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            // A restart suppresses the write even if a beat is offered.
            if (loadStart) begin
               ptr_d   = '0;
               count_d = '0;
            end else begin
               if (accept_s) begin
                  we_s    = 1'b1;
                  ptr_d   = ptr_q + ADDR_WIDTH'(1);
                  count_d = count_q + (ADDR_WIDTH+1)'(1);
               end else begin
                  we_s = 1'b0;
               end
               if (loadEnd || (accept_s && last_s)) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         default: begin
            state_d = ST_INIT;
            ptr_d   = '0;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
         count_q <= '0;
         data_q  <= NOP_OPCODE;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   // Single write port; reset wins over any write computed in the same cycle.
   always_ff @(posedge clk) begin
      if (we_s && !reset) begin
         mem_q[waddr_s] <= wdata_s;
      end
   end

endmodule
